// File: rtl/uart_dma_pkg.sv
// Shared encodings for the UART DMA memory responder: access widths, FSM states, port ids.
package uart_dma_pkg;

  localparam logic [1:0] MEM_ACC_8  = 2'b00;
  localparam logic [1:0] MEM_ACC_16 = 2'b01;
  localparam logic [1:0] MEM_ACC_32 = 2'b10;

  localparam logic PORT_RD = 1'b0;
  localparam logic PORT_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } dma_state_e;

  // Reserved width 2'b11 behaves as a byte access.
  function automatic logic [1:0] norm_width(input logic [1:0] width);
    return (width == 2'b11) ? MEM_ACC_8 : width;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      MEM_ACC_16: return lo[0];
      MEM_ACC_32: return lo != 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

  // Byte lane after forcing alignment to the access size.
  function automatic logic [1:0] align_lane(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      MEM_ACC_16: return {lo[1], 1'b0};
      MEM_ACC_32: return 2'b00;
      default:    return lo;
    endcase
  endfunction

endpackage

// File: rtl/uart_dma_bram.sv
// Single-port 32-bit RAM with byte enables and a one-cycle registered read; contents are not reset.
module uart_dma_bram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/uart_dma_mem_responder.sv
// Round-robin responder serving the UART TX-read and RX-write DMA ports from a local RAM.
module uart_dma_mem_responder
  import uart_dma_pkg::*;
#(
  parameter int unsigned M_WIDTH     = 32,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_req,
  input  logic [M_WIDTH-1:0] rd_addr,
  input  logic [1:0]         rd_width,
  output logic [M_WIDTH-1:0] rd_data,
  output logic               rd_ready,
  input  logic               wr_req,
  input  logic [M_WIDTH-1:0] wr_addr,
  input  logic [1:0]         wr_width,
  input  logic [M_WIDTH-1:0] wr_data,
  output logic               wr_ready,
  output logic               misalign
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dma_state_e         state_q, state_d;
  logic               last_q, last_d;
  logic               port_q, port_d;
  logic [AW-1:0]      widx_q, widx_d;
  logic [1:0]         lane_q, lane_d;
  logic [1:0]         width_q, width_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               misalign_q, misalign_d;

  logic               gnt;
  logic [M_WIDTH-1:0] g_addr;
  logic [1:0]         g_width;
  logic               ram_en;
  logic [3:0]         ram_we;
  logic [31:0]        ram_wdata, ram_rdata, rsteer;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^g_addr[M_WIDTH-1:AW+2];

  // Contention goes to the port not served last; a lone requester always wins.
  always_comb begin
    if (rd_req && wr_req) gnt = (last_q == PORT_RD) ? PORT_WR : PORT_RD;
    else                  gnt = wr_req ? PORT_WR : PORT_RD;
    g_addr  = (gnt == PORT_WR) ? wr_addr : rd_addr;
    g_width = norm_width((gnt == PORT_WR) ? wr_width : rd_width);
  end

  always_comb begin
    rsteer = ram_rdata;
    case (width_q)
      MEM_ACC_32: rsteer = ram_rdata;
      MEM_ACC_16: rsteer = lane_q[1] ? {16'h0, ram_rdata[31:16]} : {16'h0, ram_rdata[15:0]};
      default: begin
        case (lane_q)
          2'd0:    rsteer = {24'h0, ram_rdata[7:0]};
          2'd1:    rsteer = {24'h0, ram_rdata[15:8]};
          2'd2:    rsteer = {24'h0, ram_rdata[23:16]};
          default: rsteer = {24'h0, ram_rdata[31:24]};
        endcase
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    port_d     = port_q;
    widx_d     = widx_q;
    lane_d     = lane_q;
    width_d    = width_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    misalign_d = misalign_q;
    ram_en     = 1'b0;
    ram_we     = '0;
    ram_wdata  = wdata_q;
    rd_ready   = 1'b0;
    wr_ready   = 1'b0;
    rd_data    = rd_data_q;

    case (state_q)
      IDLE: begin
        if (rd_req || wr_req) begin
          port_d     = gnt;
          last_d     = gnt;
          widx_d     = g_addr[AW+1:2];
          lane_d     = align_lane(g_width, g_addr[1:0]);
          width_d    = g_width;
          wdata_d    = wr_data;
          misalign_d = misalign_q | is_misaligned(g_width, g_addr[1:0]);
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        ram_en = 1'b1;
        if (port_q == PORT_WR) begin
          case (width_q)
            MEM_ACC_32: begin
              ram_we    = '1;
              ram_wdata = wdata_q;
            end
            MEM_ACC_16: begin
              ram_we    = lane_q[1] ? 4'b1100 : 4'b0011;
              ram_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
              ram_we    = 4'b0001 << lane_q;
              ram_wdata = {4{wdata_q[7:0]}};
            end
          endcase
        end
        state_d = RESPOND;
      end
      RESPOND: begin
        if (port_q == PORT_RD) begin
          rd_ready  = 1'b1;
          rd_data   = rsteer;
          rd_data_d = rsteer;
        end else begin
          wr_ready = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= PORT_WR;
      port_q     <= PORT_RD;
      widx_q     <= '0;
      lane_q     <= '0;
      width_q    <= MEM_ACC_8;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      port_q     <= port_d;
      widx_q     <= widx_d;
      lane_q     <= lane_d;
      width_q    <= width_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;

  uart_dma_bram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (widx_q),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_uart_dma_mem_responder.sv
// Bench for uart_dma_mem_responder: directed scenarios plus randomized traffic against a byte-array model.
module tb_uart_dma_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned MEMB  = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [31:0] rd_addr, wr_addr, wr_data;
  logic [1:0]  rd_width, wr_width;
  logic [31:0] rd_data;
  logic        rd_ready, wr_ready, misalign;

  always #5 clk = ~clk;

  uart_dma_mem_responder #(
    .M_WIDTH    (32),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_width(rd_width),
    .rd_data (rd_data),
    .rd_ready(rd_ready),
    .wr_req  (wr_req),
    .wr_addr (wr_addr),
    .wr_width(wr_width),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .misalign(misalign)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: byte-addressed memory and transaction-level timing.
  bit          started = 1'b0;
  byte unsigned mem_m [MEMB];
  int          cyc = 0, resp_cyc = -1, free_cyc = 0;
  bit          resp_wr = 1'b0, last_wr = 1'b1, exp_mis = 1'b0;
  logic [31:0] resp_val = '0, exp_rd = '0;

  function automatic int unsigned size_of(input logic [1:0] w);
    case (w)
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (started) begin
      bit          er, ew, use_wr;
      logic [31:0] a, v;
      int unsigned sz;
      er = (resp_cyc == cyc) && !resp_wr;
      ew = (resp_cyc == cyc) && resp_wr;
      if (er) exp_rd = resp_val;
      chk("rd_ready", {31'b0, rd_ready}, {31'b0, er});
      chk("wr_ready", {31'b0, wr_ready}, {31'b0, ew});
      chk("rd_data", rd_data, exp_rd);
      chk("misalign", {31'b0, misalign}, {31'b0, exp_mis});
      if (rst) begin
        resp_cyc = -1;
        free_cyc = cyc + 1;
        exp_rd   = '0;
        exp_mis  = 1'b0;
        last_wr  = 1'b1;
      end else if (cyc >= free_cyc && (rd_req || wr_req)) begin
        use_wr = (rd_req && wr_req) ? !last_wr : wr_req;
        a  = use_wr ? wr_addr : rd_addr;
        sz = size_of(use_wr ? wr_width : rd_width);
        if (a % sz != 0) exp_mis = 1'b1;
        a = (a - (a % sz)) % MEMB;
        v = '0;
        for (int unsigned i = 0; i < sz; i++) begin
          if (use_wr) mem_m[a + i] = wr_data[8*i +: 8];
          else        v = v | (32'(mem_m[a + i]) << (8 * i));
        end
        resp_val = v;
        resp_wr  = use_wr;
        resp_cyc = cyc + 2;
        free_cyc = cyc + 3;
        last_wr  = use_wr;
      end
      cyc++;
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d,
                          output int lat);
    wr_req = 1'b1; wr_addr = a; wr_width = w; wr_data = d; lat = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (wr_ready) begin lat = k; break; end
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
    if (lat < 0) chk("wr_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] w,
                         output logic [31:0] d, output int lat);
    rd_req = 1'b1; rd_addr = a; rd_width = w; lat = -1; d = 'x;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rd_ready) begin lat = k; d = rd_data; break; end
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    if (lat < 0) chk("rd_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, n;
    logic [31:0] d;
    int          who [4];
    int          when [4];
    bit          rp, wp, srd, swr;

    rst = 1'b1; rd_req = 0; wr_req = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; rd_width = 2'b00; wr_width = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) do_write(32'(i * 4), 2'b10, $urandom, lat);

    do_write(32'h10, 2'b10, 32'hDEADBEEF, lat);
    chk("word_wr_latency", lat, 2);
    do_read(32'h10, 2'b10, d, lat);
    chk("word_rd_latency", lat, 2);
    chk("word_rd_data", d, 32'hDEADBEEF);

    do_write(32'h20, 2'b00, 32'hFFFFFF11, lat);
    do_write(32'h21, 2'b00, 32'h00000022, lat);
    do_write(32'h22, 2'b11, 32'h12345633, lat);
    do_write(32'h23, 2'b00, 32'h00000044, lat);
    do_read(32'h20, 2'b10, d, lat);
    chk("bytes_as_word", d, 32'h44332211);
    do_read(32'h22, 2'b01, d, lat);
    chk("half_upper", d, 32'h00004433);
    do_read(32'h23, 2'b00, d, lat);
    chk("byte_lane3", d, 32'h00000044);

    do_write(32'h32, 2'b10, 32'hCAFEF00D, lat);
    chk("misalign_set", {31'b0, misalign}, 32'd1);
    do_read(32'h1030, 2'b10, d, lat);
    chk("wrap_read", d, 32'hCAFEF00D);
    chk("misalign_sticky", {31'b0, misalign}, 32'd1);

    do_reset();
    rd_req = 1'b1; rd_addr = 32'h10; rd_width = 2'b10;
    wr_req = 1'b1; wr_addr = 32'h3C; wr_width = 2'b10; wr_data = 32'h0BADF00D;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (rd_ready)      begin who[n] = 0; when[n] = k; n++; end
      else if (wr_ready) begin who[n] = 1; when[n] = k; n++; end
    end
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 1'b0;
    chk("contention_count", n, 4);
    for (int i = 0; i < n; i++) chk("contention_order", who[i], i % 2);
    for (int i = 1; i < n; i++) chk("contention_gap", when[i] - when[i-1], 3);

    rd_req = 1'b1; rd_addr = 32'h10; rd_width = 2'b10;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (rd_ready) begin when[n] = k; n++; end
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    chk("held_count", n, 4);
    for (int i = 1; i < n; i++) chk("held_gap", when[i] - when[i-1], 3);

    rd_req = 1'b1; rd_addr = 32'h20; rd_width = 2'b10;
    @(posedge clk); #1;
    rst = 1'b1; rd_req = 1'b0;
    n = 0;
    @(negedge clk);
    n += int'(rd_ready) + int'(wr_ready);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rd_data", rd_data, 32'h0);
    n += int'(rd_ready) + int'(wr_ready);
    repeat (2) begin
      @(negedge clk);
      n += int'(rd_ready) + int'(wr_ready);
    end
    chk("reset_no_ready", n, 0);
    @(posedge clk); #1;
    do_read(32'h10, 2'b10, d, lat);
    chk("post_reset_latency", lat, 2);
    chk("post_reset_data", d, 32'hDEADBEEF);

    rp = 1'b0; wp = 1'b0;
    for (int it = 0; it < 2000; it++) begin
      @(negedge clk);
      srd = rd_ready; swr = wr_ready;
      @(posedge clk); #1;
      if (rp && srd) rp = 1'b0;
      if (wp && swr) wp = 1'b0;
      if (!rp) begin
        if ($urandom_range(0, 9) < 6) begin
          rp = 1'b1; rd_req = 1'b1; rd_addr = rand_addr(); rd_width = 2'($urandom_range(0, 3));
        end else rd_req = 1'b0;
      end
      if (!wp) begin
        if ($urandom_range(0, 9) < 6) begin
          wp = 1'b1; wr_req = 1'b1; wr_addr = rand_addr(); wr_width = 2'($urandom_range(0, 3));
          wr_data = $urandom;
        end else wr_req = 1'b0;
      end
    end
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_dma_mem_responder.md
Name: uart_dma_mem_responder

Overview:
Memory-side responder for the UART's two DMA initiators: the TX read port and the RX write port. Arbitrates between them and serves each request from an on-block byte-addressed, word-organised RAM, using the same req/ready/width handshake the UART drives. Sits between the uart instance and the shared buffer memory. Firmware-visible TX and RX DMA buffers live in this RAM.

Parameters:
M_WIDTH, 32, address/data width; fixed at 32 for this block
DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two
MEM_ACC_8, 2'b00, byte access encoding
MEM_ACC_16, 2'b01, halfword access encoding
MEM_ACC_32, 2'b10, word access encoding

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
rd_req  in  1  TX-side read request, level, held until rd_ready
rd_addr  in  M_WIDTH  byte address
rd_width  in  2  access width
rd_data  out  M_WIDTH  read data, LSB-aligned, zero-extended
rd_ready  out  1  one-cycle completion pulse
wr_req  in  1  RX-side write request, level, held until wr_ready
wr_addr  in  M_WIDTH  byte address
wr_width  in  2  access width
wr_data  in  M_WIDTH  write data, LSB-aligned
wr_ready  out  1  one-cycle completion pulse
misalign  out  1  sticky flag: misaligned access seen

Behaviour:
- Reset: rd_ready=0, wr_ready=0, rd_data=0, misalign=0, FSM=IDLE, round-robin pointer favours rd. RAM contents not reset.
- Handshake: initiator holds req, addr, width, and data stable until ready. Ready is high for exactly one cycle. A port is not eligible for grant in the cycle its ready is high. If req is still high in the following cycle, that is a new request.
- FSM states: IDLE, ACCESS, RESPOND.
  - IDLE: if any eligible req is high, grant one, latch addr/width/data/port, go to ACCESS.
  - ACCESS: RAM read or byte-enabled write issued; go to RESPOND.
  - RESPOND: pulse the granted port's ready; for reads, drive rd_data the same cycle; return to IDLE.
- Latency: req high in cycle N while in IDLE gives ready high in cycle N+2. Back-to-back throughput is one access per 3 cycles.
- Arbitration: round-robin. On simultaneous eligible requests, grant the port not served last. A single requester is always granted.
- rd_data holds its value until the next read completes. A write never changes rd_data.
- Addressing: little-endian. Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo RAM size.
- Width rules:
  - 8-bit: byte lane addr[1:0]; write stores wr_data[7:0]; read returns that byte in [7:0], upper bits 0.
  - 16-bit: lane pair selected by addr[1]; write stores wr_data[15:0]; read returns the halfword in [15:0].
  - 32-bit: full word.
  - Width 2'b11 is reserved and treated as 8-bit.
- Misalignment: a 16-bit access with addr[0]=1, or a 32-bit access with addr[1:0]!=0, is force-aligned down (low bits masked) and completes normally. misalign sets and stays set until rst.
- A req dropped before ready is a protocol violation. The latched request still completes and ready still pulses.
- Reset mid-operation: any in-flight access is abandoned and no ready is issued. A write in ACCESS at the reset edge may or may not land.

Decomposition:
- Shared package uart_dma_pkg:
  - width encodings MEM_ACC_8/16/32
  - FSM state enum {IDLE, ACCESS, RESPOND}
  - port-id constants PORT_RD, PORT_WR
- One sub-module, uart_dma_bram: single-port 32-bit RAM, 4 byte enables, 1-cycle registered read, no reset.
- Top level holds the FSM, arbiter, lane steering, and misalign flag.

Test Plan:
- Word write then read: wr 32-bit addr 0x10 data 0xDEADBEEF → wr_ready at N+2. Then rd 32-bit 0x10 → rd_data=0xDEADBEEF, rd_ready at N+2.
- Byte/halfword lanes:
  - 8-bit writes 0x11,0x22,0x33,0x44 to 0x20..0x23; 32-bit read 0x20 → 0x44332211.
  - 16-bit read 0x22 → 0x00004433.
  - 8-bit read 0x23 → 0x00000044.
- Contention: rd_req and wr_req rise in the same cycle after reset, both held with a new request each time → grants alternate rd, wr, rd, wr. Ready pulses are 3 cycles apart, never both high.
- Misaligned and wrap:
  - 32-bit write 0x32 data 0xCAFEF00D → lands at 0x30; misalign=1 and stays 1.
  - With DEPTH_WORDS=1024, read 0x1030 → 0xCAFEF00D.
- Held req: rd_req held high continuously on an idle bus → rd_ready pulses every 3 cycles, never on consecutive cycles.
- Reset mid-access: assert rst during ACCESS → no ready pulse, outputs at reset values next cycle. A fresh request after reset completes in 2 cycles.
